// File: rtl/crc_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crc_stream_pkg : shared types and sizing helpers for the appender     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package crc_stream_pkg;

  typedef enum logic [0:0] {
    PASS   = 1'b0,
    APPEND = 1'b1
  } state_t;

  localparam int CNT_W_MIN = 1;

  function automatic int crc_bytes(input int width);
    return width / 8;
  endfunction

  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width / 8);
    return (w < CNT_W_MIN) ? CNT_W_MIN : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc_generator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crc_generator : MSB-first, non-reflected parallel CRC engine          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module crc_generator #(
  parameter int                  DATAWIDTH  = 8,
  parameter int                  CRCWIDTH   = 16,
  parameter logic [CRCWIDTH-1:0] POLYNOMIAL = 'h8005,
  parameter logic [CRCWIDTH-1:0] INITCRC    = 'hFFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clkena,
  input  logic                 init,
  input  logic [DATAWIDTH-1:0] data,
  output logic [CRCWIDTH-1:0]  crc_old,
  output logic [CRCWIDTH-1:0]  crc_new
);

  logic [CRCWIDTH-1:0] r_crc;

  always_comb begin
    logic [CRCWIDTH-1:0] v;
    v = r_crc;
    for (int i = DATAWIDTH - 1; i >= 0; i--) begin
      if (v[CRCWIDTH-1] ^ data[i]) v = (v << 1) ^ POLYNOMIAL;
      else                         v = v << 1;
    end
    crc_new = v;
  end

  // init wins over the update so the engine restarts cleanly after the last byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_crc <= INITCRC;
    else if (clkena) r_crc <= init ? INITCRC : crc_new;
  end

  assign crc_old = r_crc;

endmodule
`default_nettype wire

// File: rtl/crc_stream_appender.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crc_stream_appender : forwards sop/eop byte packets and appends the   |
// | CRC MSB first. Optional macro CRC_STREAM_XOROUT_EN applies XOROUT.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module crc_stream_appender
  import crc_stream_pkg::*;
#(
  parameter int                  CRCWIDTH   = 16,
  parameter logic [CRCWIDTH-1:0] POLYNOMIAL = 16'h8005,
  parameter logic [CRCWIDTH-1:0] INITCRC    = 16'hFFFF,
  parameter logic [CRCWIDTH-1:0] XOROUT     = 16'hFFFF
) (
  input  logic       reset,
  input  logic       clk,
  input  logic [7:0] i_dat,
  input  logic       i_val,
  input  logic       i_sop,
  input  logic       i_eop,
  output logic       i_rdy,
  output logic [7:0] o_dat,
  output logic       o_val,
  output logic       o_sop,
  output logic       o_eop,
  input  logic       o_rdy,
  output logic       err_sop,
  output logic       err_eop
);

  localparam int              NBYTES = crc_bytes(CRCWIDTH);
  localparam int              CNTW   = cnt_width(CRCWIDTH);
  localparam logic [CNTW-1:0] C_LAST = CNTW'(NBYTES - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_in_pkt;
  logic [CRCWIDTH-1:0] r_hold;
  logic [CNTW-1:0]     r_cnt;
  logic                r_err_sop;
  logic                r_err_eop;

  logic                w_i_rdy;
  logic                w_acc;
  logic                w_last;
  logic [CRCWIDTH-1:0] w_crc_new;
  logic [CRCWIDTH-1:0] w_crc_unused;
  logic [CRCWIDTH-1:0] w_hold_next;

  assign w_i_rdy = (r_state == PASS) & o_rdy;
  assign w_acc   = i_val & w_i_rdy;
  assign w_last  = (r_cnt == C_LAST);
  assign i_rdy   = w_i_rdy;

  crc_generator #(
    .DATAWIDTH (8),
    .CRCWIDTH  (CRCWIDTH),
    .POLYNOMIAL(POLYNOMIAL),
    .INITCRC   (INITCRC)
  ) u_crc (
    .clk    (clk),
    .reset  (reset),
    .clkena (w_acc),
    .init   (w_acc & i_eop),
    .data   (i_dat),
    .crc_old(w_crc_unused),
    .crc_new(w_crc_new)
  );

`ifdef CRC_STREAM_XOROUT_EN
  assign w_hold_next = w_crc_new ^ XOROUT;
`else
  logic [CRCWIDTH-1:0] w_xorout_unused;
  assign w_xorout_unused = XOROUT;
  assign w_hold_next     = w_crc_new;
`endif

  always_comb begin
    w_state_next = r_state;
    o_dat        = i_dat;
    o_val        = i_val;
    o_sop        = i_sop;
    o_eop        = 1'b0;
    case (r_state)
      PASS: begin
        if (w_acc && i_eop) w_state_next = APPEND;
      end
      APPEND: begin
        o_val = 1'b1;
        o_sop = 1'b0;
        o_dat = r_hold[CRCWIDTH-1-8*int'(r_cnt) -: 8];
        o_eop = w_last;
        if (o_rdy && w_last) w_state_next = PASS;
      end
      default: w_state_next = PASS;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= PASS;
      r_in_pkt  <= 1'b0;
      r_hold    <= '0;
      r_cnt     <= '0;
      r_err_sop <= 1'b0;
      r_err_eop <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_err_sop <= w_acc & i_sop & r_in_pkt;
      r_err_eop <= w_acc & ~i_sop & ~r_in_pkt;
      if (w_acc && i_eop)      r_in_pkt <= 1'b0;
      else if (w_acc && i_sop) r_in_pkt <= 1'b1;
      if (w_acc && i_eop) begin
        r_hold <= w_hold_next;
        r_cnt  <= '0;
      end else if (r_state == APPEND && o_rdy) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

  assign err_sop = r_err_sop;
  assign err_eop = r_err_eop;

endmodule
`default_nettype wire

// File: tb/tb_crc_stream_appender.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_crc_stream_appender : randomized bench with packet-level CRC model |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_crc_stream_appender;

  logic       reset, clk;
  logic [7:0] i_dat;
  logic       i_val, i_sop, i_eop, i_rdy;
  logic [7:0] o_dat;
  logic       o_val, o_sop, o_eop, o_rdy;
  logic       err_sop, err_eop;

  crc_stream_appender #(
    .CRCWIDTH(16), .POLYNOMIAL(16'h8005), .INITCRC(16'hFFFF), .XOROUT(16'hFFFF)
  ) dut (
    .reset(reset), .clk(clk),
    .i_dat(i_dat), .i_val(i_val), .i_sop(i_sop), .i_eop(i_eop), .i_rdy(i_rdy),
    .o_dat(o_dat), .o_val(o_val), .o_sop(o_sop), .o_eop(o_eop), .o_rdy(o_rdy),
    .err_sop(err_sop), .err_eop(err_eop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CRC_STREAM_XOROUT_EN
  localparam logic [15:0] CHECK = 16'h5118;
`else
  localparam logic [15:0] CHECK = 16'hAEE7;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Model state: expected output stream {dat,sop,eop} and bytes of the current CRC run
  logic [9:0] exp_q[$];
  logic [7:0] cur[$];
  logic [7:0] out_log[$];
  logic       m_in_pkt = 1'b0;
  logic       exp_err_sop = 1'b0, exp_err_eop = 1'b0;
  logic       acc_seen = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dat;
  logic       prev_eop;
  int         rdy_low_cnt = 0;
  int         err_sop_cnt = 0;
  int         rdy_mode = 0;

  function automatic logic [15:0] crc_model(input logic [7:0] b[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (b[k]) begin
      for (int i = 7; i >= 0; i--) begin
        fb = c[15] ^ b[k][i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
`ifdef CRC_STREAM_XOROUT_EN
    c = c ^ 16'hFFFF;
`endif
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       o_rdy = 1'b1;
      1:       o_rdy = 1'($urandom_range(0, 1));
      default: o_rdy = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    logic [15:0] c;
    logic [9:0]  e;
    if (reset) begin
      exp_q.delete(); cur.delete();
      m_in_pkt = 0; exp_err_sop = 0; exp_err_eop = 0;
      acc_seen = 0; prev_stall = 0;
    end else begin
      check("err_sop", err_sop, exp_err_sop);
      check("err_eop", err_eop, exp_err_eop);
      if (err_sop) err_sop_cnt++;
      check("i_rdy", i_rdy, o_rdy && (exp_q.size() == 0));
      if (!i_rdy) rdy_low_cnt++;
      if (prev_stall) begin
        check("stall_val", o_val, 1'b1);
        check("stall_dat", o_dat, prev_dat);
        check("stall_eop", o_eop, prev_eop);
      end
      acc_seen = i_val && i_rdy;
      exp_err_sop = 0; exp_err_eop = 0;
      if (acc_seen) begin
        exp_q.push_back({i_dat, i_sop, 1'b0});
        cur.push_back(i_dat);
        exp_err_sop = i_sop && m_in_pkt;
        exp_err_eop = !i_sop && !m_in_pkt;
        if (i_eop) begin
          c = crc_model(cur);
          cur.delete();
          exp_q.push_back({c[15:8], 2'b00});
          exp_q.push_back({c[7:0], 2'b01});
          m_in_pkt = 0;
        end else if (i_sop) begin
          m_in_pkt = 1;
        end
      end
      if (o_val && o_rdy) begin
        out_log.push_back(o_dat);
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("o_dat", o_dat, e[9:2]);
          check("o_sop", o_sop, e[1]);
          check("o_eop", o_eop, e[0]);
        end
      end
      prev_stall = o_val && !o_rdy;
      prev_dat   = o_dat;
      prev_eop   = o_eop;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    int t;
    i_dat = d; i_sop = s; i_eop = e; i_val = 1'b1;
    t = 0;
    do begin
      @(posedge clk); #1; t++;
    end while (!acc_seen && t < 300);
    if (!acc_seen) check("accept_timeout", t, 0);
    i_val = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b[$], input int stray, input bit nosop, input bit gaps);
    foreach (b[k]) begin
      send_byte(b[k], (k == 0 && !nosop) || (k == stray), k == b.size() - 1);
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
      if (gaps) #1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk); #1; t++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic check_tail(input string name, input int idx);
    check({name, "_msb"}, (out_log.size() > idx) ? out_log[idx] : 8'hxx, CHECK[15:8]);
    check({name, "_lsb"}, (out_log.size() > idx + 1) ? out_log[idx+1] : 8'hxx, CHECK[7:0]);
  endtask

  logic [7:0] q9[$];
  logic [7:0] qs[$];
  logic [7:0] qr[$];

  initial begin
    q9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    reset = 1'b1; i_dat = 8'h00; i_val = 1'b0; i_sop = 1'b0; i_eop = 1'b0; o_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_o_val", o_val, 1'b0);
    check("rst_i_rdy", i_rdy, 1'b1);
    check("rst_err_sop", err_sop, 1'b0);
    check("rst_err_eop", err_eop, 1'b0);
    check("model_pin_check", crc_model(q9), CHECK);
    @(posedge clk); #1;

    // Directed: check string, full-rate downstream
    out_log.delete(); rdy_low_cnt = 0;
    send_pkt(q9, -1, 0, 0);
    drain();
    check("t1_len", out_log.size(), 11);
    check_tail("t1_crc", 9);
    check("t1_rdy_low", rdy_low_cnt, 2);

    // Back-to-back with random backpressure
    rdy_mode = 1; out_log.delete();
    send_pkt(q9, -1, 0, 0);
    send_pkt(q9, -1, 0, 0);
    drain();
    check("t2_len", out_log.size(), 22);
    check_tail("t2_crc_a", 9);
    check_tail("t2_crc_b", 20);

    // Single-byte packet, then the check string proves the engine restarted at INITCRC
    rdy_mode = 0; out_log.delete();
    qs = '{8'h31};
    send_pkt(qs, -1, 0, 0);
    send_pkt(q9, -1, 0, 0);
    drain();
    check("t3_len", out_log.size(), 14);
    check_tail("t3_crc_after", 12);

    // Stray sop inside a packet
    err_sop_cnt = 0;
    qs = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    send_pkt(qs, 4, 0, 0);
    drain();
    @(posedge clk); #1;
    check("t4_err_sop_pulses", err_sop_cnt, 1);

    // Packet with no sop
    qs = '{8'hA5, 8'h5A, 8'h00};
    send_pkt(qs, -1, 1, 0);
    drain();

    // Reset while the second CRC byte is stalled
    send_pkt(q9, -1, 0, 0);
    @(posedge clk); #1 rdy_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    check("t5_stalled_val", o_val, 1'b1);
    check("t5_stalled_dat", o_dat, CHECK[7:0]);
    reset = 1'b1;
    #1;
    check("t5_reset_val", o_val, 1'b0);
    repeat (2) @(posedge clk);
    #1 rdy_mode = 0; reset = 1'b0;
    @(posedge clk); #1;
    out_log.delete();
    send_pkt(q9, -1, 0, 0);
    drain();
    check("t5_len", out_log.size(), 11);
    check_tail("t5_crc", 9);

    // Randomized packets: lengths, data, gaps, stray/missing sop, backpressure
    rdy_mode = 1;
    for (int p = 0; p < 40; p++) begin
      qr.delete();
      repeat ($urandom_range(1, 12)) qr.push_back(8'($urandom));
      send_pkt(qr, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 6)) : -1,
               $urandom_range(0, 9) == 0, 1);
    end
    drain();
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
